// File: rtl/rns_pkg.sv
// Shared state encoding and modulus/inverse constants for the RNS (2^N, 2^N-1, 2^N+1) converter.
package rns_pkg;

  typedef enum logic [2:0] {IDLE, D2, D3, ACC, OUT} rns_state_t;

  function automatic logic [63:0] mod_lo(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] mod_hi(input int n);
    return (64'd1 << n) + 64'd1;
  endfunction

  function automatic logic [63:0] inv_hi(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/rns_mod_sub.sv
// Modular subtract y = (a - b) mod m, m = 2^N+1 when PLUS else 2^N-1; operands may arrive unreduced,
// each is folded by one conditional subtract and the difference fixed by one conditional add.
module rns_mod_sub
  import rns_pkg::*;
#(
  parameter int N = 16,
  parameter bit PLUS = 1'b0,
  localparam int W = PLUS ? N + 1 : N
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W:0] MOD = PLUS ? (W+1)'(mod_hi(N)) : (W+1)'(mod_lo(N));

  logic [W:0] ar;
  logic [W:0] br;
  logic [W:0] diff;

  always_comb begin
    ar = {1'b0, a};
    br = {1'b0, b};
    if (ar >= MOD) ar = ar - MOD;
    if (br >= MOD) br = br - MOD;
    diff = ar - br;
    if (ar < br) diff = diff + MOD;
    y = W'(diff);
  end

endmodule

// File: rtl/rns_to_int_seq.sv
// Sequential RNS-to-binary converter (mixed-radix digits, one conversion in flight, 5 cycles per result).
// Optional range-error flag is built only when RNS_TO_INT_RANGE_CHECK_EN is defined.
module rns_to_int_seq
  import rns_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   r1,
  input  logic [N-1:0]   r2,
  input  logic [N:0]     r3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*N-1:0] out_data,
  output logic           out_err
);

  rns_state_t state, state_nxt;
  logic run, accept;
  logic [N-1:0] d1, r2_q, d2, d2_nxt, lo, hi;
  logic [N:0] r3_q, u, d3, d3_nxt, sub3_a, sub3_b, sub3_y;
  logic [N+1:0] t;
  logic [3*N-1:0] x;

  // run holds in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = run;
        if (run && in_valid) begin
          accept    = 1'b1;
          state_nxt = D2;
        end
      end
      D2:  state_nxt = D3;
      D3:  state_nxt = ACC;
      ACC: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  rns_mod_sub #(.N(N), .PLUS(1'b0)) u_sub_lo (.a(r2_q), .b(d1), .y(d2_nxt));

  // The 2^N+1 subtractor forms d1-r3 in D2 and (d1-r3)-d2 in D3.
  assign sub3_a = (state == D3) ? u : {1'b0, d1};
  assign sub3_b = (state == D3) ? {1'b0, d2} : r3_q;
  rns_mod_sub #(.N(N), .PLUS(1'b1)) u_sub_hi (.a(sub3_a), .b(sub3_b), .y(sub3_y));

  // s * 2^(N-1) mod 2^N+1: the bits shifted past 2^N fold back negatively since 2^N == -1.
  always_comb begin
    lo = sub3_y[0] ? N'(inv_hi(N)) : '0;
    hi = sub3_y[N:1];
    t  = {2'b00, lo} - {2'b00, hi};
    if (lo < hi) t = t + (N+2)'(mod_hi(N));
    d3_nxt = (N+1)'(t);
  end

  // x = d1 + 2^N*(d2 + (2^N-1)*d3); wrap-around in 3N bits is exact because x < M.
  assign x = (3*N)'({d3, {(2*N){1'b0}}}) - (3*N)'({d3, {N{1'b0}}}) + (3*N)'({d2, d1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1       <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      d2       <= '0;
      u        <= '0;
      d3       <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        d1   <= r1;
        r2_q <= r2;
        r3_q <= r3;
      end
      if (state == D2) begin
        d2 <= d2_nxt;
        u  <= sub3_y;
      end
      if (state == D3) d3 <= d3_nxt;
      if (state == ACC) out_data <= x;
    end
  end

`ifdef RNS_TO_INT_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ACC) begin
      err_q <= (&r2_q) || (r3_q[N] && (|r3_q[N-1:0]));
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
